// File: rtl/hazard_ctrl.sv
// Load-use stall and forwarding control for a five-stage pipeline.
// Shadows the destination info of the EX and MEM instructions to detect hazards on ID sources.
module hazard_ctrl (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [4:0]  Rs,
    input  logic [4:0]  Rt,
    input  logic        UseRs,
    input  logic        UseRt,
    input  logic        Wreg,
    input  logic        Reg2reg,
    input  logic [4:0]  Rd,
    input  logic        Flush,
    output logic        stall,
    output logic        We,
    output logic [1:0]  FwdA,
    output logic [1:0]  FwdB,
    output logic [15:0] StallCnt
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    logic        e_wreg_q, e_wreg_d;
    logic        e_r2r_q,  e_r2r_d;
    logic [4:0]  e_rd_q,   e_rd_d;
    logic        m_wreg_q, m_wreg_d;
    logic        m_r2r_q,  m_r2r_d;
    logic [4:0]  m_rd_q,   m_rd_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic [1:0][4:0] src;
    logic [1:0]      use_src;
    logic [1:0]      e_hit;
    logic [1:0]      m_hit;
    logic [1:0]      load_hit;
    logic [1:0][1:0] fwd;
    logic            kill_fwd;

    assign src     = {Rt, Rs};
    assign use_src = {UseRt, UseRs};

    // Fwd codes are meaningless while the ID instruction is bubbled, killed or in reset.
    assign kill_fwd = Rst | stall | Flush;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            assign e_hit[gi]    = e_wreg_q & (e_rd_q == src[gi]) & (|src[gi]);
            assign m_hit[gi]    = m_wreg_q & (m_rd_q == src[gi]) & (|src[gi]);
            assign load_hit[gi] = use_src[gi] & e_hit[gi] & ~e_r2r_q;
            assign fwd[gi] = kill_fwd                            ? FWD_RF  :
                             (use_src[gi] & e_hit[gi] & e_r2r_q) ? FWD_MEM :
                             m_hit[gi]                           ? FWD_WB  :
                                                                   FWD_RF;
        end
    endgenerate

    assign stall    = ~Rst & ~Flush & (|load_hit);
    assign We       = ~stall;
    assign FwdA     = fwd[0];
    assign FwdB     = fwd[1];
    assign StallCnt = stall_cnt_q;

    always_comb begin
        e_wreg_d    = Wreg;
        e_r2r_d     = Reg2reg;
        e_rd_d      = Rd;
        m_wreg_d    = e_wreg_q;
        m_r2r_d     = e_r2r_q;
        m_rd_d      = e_rd_q;
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (stall || Flush) begin
            e_wreg_d = 1'b0;
            e_r2r_d  = 1'b1;
            e_rd_d   = 5'd0;
        end
        if (Rst) begin
            e_wreg_d    = 1'b0;
            e_r2r_d     = 1'b1;
            e_rd_d      = 5'd0;
            m_wreg_d    = 1'b0;
            m_r2r_d     = 1'b1;
            m_rd_d      = 5'd0;
            stall_cnt_d = 16'd0;
        end
    end

    always_ff @(posedge Clk) begin
        e_wreg_q    <= e_wreg_d;
        e_r2r_q     <= e_r2r_d;
        e_rd_q      <= e_rd_d;
        m_wreg_q    <= m_wreg_d;
        m_r2r_q     <= m_r2r_d;
        m_rd_q      <= m_rd_d;
        stall_cnt_q <= stall_cnt_d;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic
// compared against a pipeline-occupancy model.
module tb_hazard_ctrl;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [4:0]  Rs, Rt, Rd;
    logic        UseRs, UseRt, Wreg, Reg2reg, Flush;
    logic        stall, We;
    logic [1:0]  FwdA, FwdB;
    logic [15:0] StallCnt;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    hazard_ctrl dut (
        .Clk(Clk), .Rst(Rst), .Rs(Rs), .Rt(Rt), .UseRs(UseRs), .UseRt(UseRt),
        .Wreg(Wreg), .Reg2reg(Reg2reg), .Rd(Rd), .Flush(Flush),
        .stall(stall), .We(We), .FwdA(FwdA), .FwdB(FwdB), .StallCnt(StallCnt)
    );

    // Model: which instruction occupies EX and MEM, and how many stalls have happened.
    typedef struct packed {
        logic       w;
        logic       r2r;
        logic [4:0] rd;
    } ent_t;

    localparam ent_t BUBBLE = '{w: 1'b0, r2r: 1'b1, rd: 5'd0};

    ent_t        mod_ex  = BUBBLE;
    ent_t        mod_mem = BUBBLE;
    int unsigned mod_cnt = 0;

    function automatic bit writes(ent_t e, logic [4:0] r);
        return e.w && (e.rd == r) && (r != 5'd0);
    endfunction

    function automatic bit exp_stall();
        bit a_needs_load, b_needs_load;
        a_needs_load = UseRs && writes(mod_ex, Rs) && !mod_ex.r2r;
        b_needs_load = UseRt && writes(mod_ex, Rt) && !mod_ex.r2r;
        return !Rst && !Flush && (a_needs_load || b_needs_load);
    endfunction

    function automatic logic [1:0] exp_fwd(logic [4:0] r, logic u);
        if (Rst || Flush || exp_stall()) return 2'b00;
        if (u && writes(mod_ex, r) && mod_ex.r2r) return 2'b01;
        if (writes(mod_mem, r)) return 2'b10;
        return 2'b00;
    endfunction

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic w, input logic r2r,
                          input logic [4:0] rd, input logic fl);
        Rs = rs; Rt = rt; UseRs = urs; UseRt = urt;
        Wreg = w; Reg2reg = r2r; Rd = rd; Flush = fl;
    endtask

    // One clock edge; the model advances from the inputs present at the edge.
    task automatic advance();
        bit s;
        @(posedge Clk);
        s = exp_stall();
        if (Rst) begin
            mod_ex = BUBBLE; mod_mem = BUBBLE; mod_cnt = 0;
        end else begin
            mod_mem = mod_ex;
            mod_ex  = (s || Flush) ? BUBBLE : '{w: Wreg, r2r: Reg2reg, rd: Rd};
            if (s && mod_cnt != 32'hFFFF) mod_cnt++;
        end
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
        advance();
        advance();
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        set_in(5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 1'b0);
        advance();
        advance();
        @(negedge Clk);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
        total++; if (We !== 1'b1) begin bad++; $display("FAIL reset_we got=%b want=1", We); end
        total++; if ({FwdA, FwdB} !== 4'b0000) begin bad++; $display("FAIL reset_fwd got=%b%b want=0000", FwdA, FwdB); end
        total++; if (StallCnt !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%h want=0000", StallCnt); end
        $display("test_reset: stall=%b We=%b FwdA=%b FwdB=%b StallCnt=%h", stall, We, FwdA, FwdB, StallCnt);
        Rst = 1'b0;
        advance();
    endtask

    task automatic test_alu_chain();
        do_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0);
        advance();
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
        @(negedge Clk);
        total++; if (FwdA !== 2'b01) begin bad++; $display("FAIL alu_fwda got=%b want=01", FwdA); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall got=%b want=0", stall); end
        total++; if (We !== 1'b1) begin bad++; $display("FAIL alu_we got=%b want=1", We); end
        $display("test_alu_chain: FwdA=%b stall=%b We=%b", FwdA, stall, We);
        advance();
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0);
        advance();
        set_in(5'd0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0);
        @(negedge Clk);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall1 got=%b want=1", stall); end
        total++; if (We !== 1'b0) begin bad++; $display("FAIL lu_we1 got=%b want=0", We); end
        total++; if (FwdB !== 2'b00) begin bad++; $display("FAIL lu_fwdb1 got=%b want=00", FwdB); end
        $display("test_load_use c1: stall=%b We=%b FwdB=%b", stall, We, FwdB);
        advance();
        @(negedge Clk);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_stall2 got=%b want=0", stall); end
        total++; if (FwdB !== 2'b10) begin bad++; $display("FAIL lu_fwdb2 got=%b want=10", FwdB); end
        total++; if (StallCnt !== 16'd1) begin bad++; $display("FAIL lu_cnt got=%h want=0001", StallCnt); end
        $display("test_load_use c2: stall=%b FwdB=%b StallCnt=%h", stall, FwdB, StallCnt);
        advance();
    endtask

    task automatic test_priority_r0();
        do_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0);
        advance();
        advance();
        set_in(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
        @(negedge Clk);
        total++; if (FwdA !== 2'b01) begin bad++; $display("FAIL prio_e_over_m got=%b want=01", FwdA); end
        $display("test_priority: both write r3 FwdA=%b", FwdA);
        advance();
        @(negedge Clk);
        total++; if (FwdA !== 2'b10) begin bad++; $display("FAIL prio_m_only got=%b want=10", FwdA); end
        $display("test_priority: MEM-only r3 FwdA=%b", FwdA);
        do_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0);
        advance();
        set_in(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0);
        @(negedge Clk);
        total++; if ({FwdA, FwdB} !== 4'b0000) begin bad++; $display("FAIL r0_fwd got=%b%b want=0000", FwdA, FwdB); end
        $display("test_r0: FwdA=%b FwdB=%b", FwdA, FwdB);
        advance();
    endtask

    task automatic test_flush();
        do_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0);
        advance();
        // Flushed instruction is an ALU writer of r9; if it leaked into EX, r9 would forward 01.
        set_in(5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 1'b1);
        @(negedge Clk);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b want=0", stall); end
        total++; if (We !== 1'b1) begin bad++; $display("FAIL flush_we got=%b want=1", We); end
        total++; if ({FwdA, FwdB} !== 4'b0000) begin bad++; $display("FAIL flush_fwd got=%b%b want=0000", FwdA, FwdB); end
        advance();
        set_in(5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
        @(negedge Clk);
        total++; if (StallCnt !== 16'd0) begin bad++; $display("FAIL flush_cnt got=%h want=0000", StallCnt); end
        total++; if (FwdA !== 2'b00) begin bad++; $display("FAIL flush_bubble got=%b want=00", FwdA); end
        $display("test_flush: next-cycle FwdA=%b StallCnt=%h", FwdA, StallCnt);
        advance();
    endtask

    task automatic test_saturation_and_reset();
        do_reset();
        // Jump the counter near its ceiling, then climb the last steps with real hazards.
        force dut.stall_cnt_q = 16'hFFF0;
        #1;
        release dut.stall_cnt_q;
        mod_cnt = 32'hFFF0;
        set_in(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0);
        advance();
        for (int i = 0; i < 17; i++) begin
            advance();
            advance();
        end
        @(negedge Clk);
        total++; if (StallCnt !== 16'hFFFF) begin bad++; $display("FAIL sat_cnt got=%h want=ffff", StallCnt); end
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL sat_stall got=%b want=1", stall); end
        advance();
        @(negedge Clk);
        total++; if (StallCnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h want=ffff", StallCnt); end
        $display("test_saturation: StallCnt=%h", StallCnt);
        advance();
        @(negedge Clk);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL sat_pre_rst got=%b want=1", stall); end
        Rst = 1'b1;
        #1;
        total++; if (stall !== 1'b0 || We !== 1'b1) begin bad++; $display("FAIL rst_mid got=%b/%b want=0/1", stall, We); end
        advance();
        Rst = 1'b0;
        @(negedge Clk);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_after_stall got=%b want=0", stall); end
        total++; if (StallCnt !== 16'd0) begin bad++; $display("FAIL rst_after_cnt got=%h want=0000", StallCnt); end
        $display("test_mid_stall_reset: stall=%b StallCnt=%h", stall, StallCnt);
        advance();
    endtask

    task automatic test_random();
        logic       e_stall;
        logic [1:0] e_fa, e_fb;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            Rst = ($urandom_range(0, 31) == 0);
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
            @(negedge Clk);
            e_stall = exp_stall();
            e_fa    = exp_fwd(Rs, UseRs);
            e_fb    = exp_fwd(Rt, UseRt);
            total++; if (stall !== e_stall) begin bad++; $display("FAIL rnd_stall n=%0d got=%b want=%b", n, stall, e_stall); end
            total++; if (We !== ~e_stall) begin bad++; $display("FAIL rnd_we n=%0d got=%b want=%b", n, We, ~e_stall); end
            total++; if (FwdA !== e_fa) begin bad++; $display("FAIL rnd_fwda n=%0d got=%b want=%b", n, FwdA, e_fa); end
            total++; if (FwdB !== e_fb) begin bad++; $display("FAIL rnd_fwdb n=%0d got=%b want=%b", n, FwdB, e_fb); end
            total++; if (StallCnt !== 16'(mod_cnt)) begin bad++; $display("FAIL rnd_cnt n=%0d got=%h want=%h", n, StallCnt, 16'(mod_cnt)); end
            $display("rnd %0d: rst=%b fl=%b rs=%0d/%b rt=%0d/%b w=%b r2r=%b rd=%0d -> stall=%b FwdA=%b FwdB=%b cnt=%0d",
                     n, Rst, Flush, Rs, UseRs, Rt, UseRt, Wreg, Reg2reg, Rd, stall, FwdA, FwdB, StallCnt);
            advance();
        end
        Rst = 1'b0;
    endtask

    initial begin
        Rst = 1'b1;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
        #1;
        test_reset();
        test_alu_chain();
        test_load_use();
        test_priority_r0();
        test_flush();
        test_saturation_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port Clk, input, 1, the single clock; all state updates on rising edge.
REQ-002 SHALL have port Rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port Rs, input, 5, first source register of the ID-stage instruction.
REQ-004 SHALL have port Rt, input, 5, second source register of the ID-stage instruction.
REQ-005 SHALL have port UseRs, input, 1, ID instruction reads Rs.
REQ-006 SHALL have port UseRt, input, 1, ID instruction reads Rt.
REQ-007 SHALL have port Wreg, input, 1, ID instruction writes the register file.
REQ-008 SHALL have port Reg2reg, input, 1, ID write source; 0 = memory data (load), 1 = ALU result.
REQ-009 SHALL have port Rd, input, 5, ID instruction destination register.
REQ-010 SHALL have port Flush, input, 1, branch taken in EX; kills the ID instruction.
REQ-011 SHALL have port stall, output, 1, clears the ID/EX register (bubble) when 1.
REQ-012 SHALL have port We, output, 1, write enable for PC and IF/ID register.
REQ-013 SHALL have port FwdA, output, 2, forward select for operand A, registered by ID/EX.
REQ-014 SHALL have port FwdB, output, 2, forward select for operand B, registered by ID/EX.
REQ-015 SHALL have port StallCnt, output, 16, count of load-use stall cycles.

Function
REQ-016 SHALL hold shadow entry E {Wreg, Reg2reg, Rd} for the instruction in EX and shadow entry M for the instruction in MEM.
REQ-017 SHALL each cycle load M from E, and load E from {Wreg, Reg2reg, Rd} unless stall or Flush is 1, in which case E loads bubble {0,1,0}.
REQ-018 SHALL treat a shadow entry as a producer of register r only when its Wreg=1, its Rd=r and r != 0.
REQ-019 SHALL assert stall=1 combinationally when Flush=0 and E is a producer (Reg2reg=0) of Rs with UseRs=1 or of Rt with UseRt=1 (load-use).
REQ-020 SHALL drive We = ~stall.
REQ-021 SHALL encode Fwd codes: 00 register file, 01 MEM-stage ALU result, 10 WB-stage write data; 11 SHALL never be generated.
REQ-022 SHALL set FwdA=01 when UseRs=1 and E produces Rs with Reg2reg=1; else 10 when M produces Rs; else 00.
REQ-023 SHALL compute FwdB by REQ-022 using Rt and UseRt.
REQ-024 SHALL give E priority over M when both produce the same register (younger result wins).
REQ-025 SHALL force FwdA=FwdB=00 whenever stall=1 or Flush=1.
REQ-026 SHALL let Flush override load-use: Flush=1 gives stall=0, We=1, E bubble next cycle.
REQ-027 SHALL increment StallCnt by 1 on each edge where stall=1, saturating at 16'hFFFF.
REQ-028 SHALL produce stall of exactly one cycle per load-use hazard; on the next cycle the load sits in M and the consumer receives Fwd=10.

Reset
REQ-029 SHALL on Rst=1 at a clock edge clear E and M to bubble and StallCnt to 0.
REQ-030 SHALL while Rst=1 drive stall=0, We=1, FwdA=FwdB=00 regardless of other inputs.
REQ-031 SHALL have reset override Flush and a pending stall when asserted mid-hazard; no StallCnt increment on that edge.

Verification
REQ-032 SHALL cover ALU chain: cycle0 Wreg=1 Reg2reg=1 Rd=5; cycle1 Rs=5 UseRs=1 -> FwdA=01, stall=0, We=1.
REQ-033 SHALL cover load-use: cycle0 Wreg=1 Reg2reg=0 Rd=8; cycle1 Rt=8 UseRt=1 -> stall=1, We=0, FwdB=00; cycle2 same inputs -> stall=0, FwdB=10, StallCnt=1.
REQ-034 SHALL cover priority and r0: E and M both write Rd=3, Rs=3 -> FwdA=01; Rd=0 producer, Rs=0 -> FwdA=00.
REQ-035 SHALL cover Flush during load-use condition -> stall=0, We=1, Fwd=00, StallCnt unchanged, next-cycle E is bubble.
REQ-036 SHALL cover StallCnt preloaded to 16'hFFFF by repeated hazards -> further stall leaves 16'hFFFF; Rst=1 mid-stall -> next cycle stall=0, StallCnt=0.
